// File: rtl/adjust_key_ctrl_if.sv
// Board-side key/switch bundle and the clean adjust strobes/levels returned to the clock core.
// master drives the raw pins and consumes the outputs; slave is the key controller itself.
interface adjust_key_ctrl_if;
  logic [5:0] key_n;
  logic       stop_sw;
  logic       dir_sw;
  logic [5:0] adj_pulse;
  logic       is_stop;
  logic       is_increase;

  modport master (
    output key_n, stop_sw, dir_sw,
    input  adj_pulse, is_stop, is_increase
  );

  modport slave (
    input  key_n, stop_sw, dir_sw,
    output adj_pulse, is_stop, is_increase
  );
endinterface

// File: rtl/adjust_key_ctrl.sv
// Sync + debounce of six adjust keys and the stop/dir switches; one-cycle adjust strobes with hold-to-repeat.
// Raw press to first strobe is 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure, strobes are fire-and-forget.
module adjust_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic               clk,
  input logic               rst_n,
  adjust_key_ctrl_if.slave  io
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  // Bit layout of the 8 sampled inputs: [7]=dir, [6]=stop, [5:0]=keys.
  localparam logic [7:0]    RAW_IDLE = 8'b1011_1111;
  localparam logic [7:0]    LVL_IDLE = 8'b1000_0000;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LOAD = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT_REL, DELAY, REPEAT} key_st_t;

  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic [7:0]    raw;
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    syn;
  logic [7:0]    lvl;
  logic [DW-1:0] db_cnt  [8];
  key_st_t       st      [6];
  logic [RW-1:0] rpt_cnt [6];
  logic [5:0]    pulse_q;

  // Assertion reaches every flop immediately; release is retimed to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  assign raw = {io.dir_sw, io.stop_sw, io.key_n};

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign syn = {sync2[7:6], ~sync2[5:0]};

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      lvl <= LVL_IDLE;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (syn[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl[i]    <= syn[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Per-key FSMs act on debounced levels; stop dropping outranks release.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pulse_q <= '0;
      for (int k = 0; k < 6; k++) begin
        st[k]      <= IDLE;
        rpt_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        pulse_q[k] <= 1'b0;
        case (st[k])
          IDLE: begin
            if (lvl[k]) begin
              if (lvl[6]) begin
                pulse_q[k] <= 1'b1;
                rpt_cnt[k] <= DLY_LOAD;
                st[k]      <= DELAY;
              end else begin
                st[k] <= WAIT_REL;
              end
            end
          end
          WAIT_REL: begin
            if (!lvl[k]) begin
              st[k] <= IDLE;
            end
          end
          DELAY, REPEAT: begin
            if (!lvl[6]) begin
              st[k] <= WAIT_REL;
            end else if (!lvl[k]) begin
              st[k] <= IDLE;
            end else if (rpt_cnt[k] == '0) begin
              pulse_q[k] <= 1'b1;
              rpt_cnt[k] <= PER_LOAD;
              st[k]      <= REPEAT;
            end else begin
              rpt_cnt[k] <= rpt_cnt[k] - 1'b1;
            end
          end
          default: st[k] <= IDLE;
        endcase
      end
    end
  end

  assign io.adj_pulse   = pulse_q;
  assign io.is_stop     = lvl[6];
  assign io.is_increase = lvl[7];

endmodule

// File: tb/tb_adjust_key_ctrl.sv
// Randomized and directed bench for adjust_key_ctrl against a hold-time reference model.
// Small debounce/repeat parameters keep every timing scenario within a few dozen cycles.
module tb_adjust_key_ctrl;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int M_IDLE  = 0;
  localparam int M_BLOCK = 1;
  localparam int M_HOLD  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  adjust_key_ctrl_if bus ();

  adjust_key_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int pcount [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: synced = raw two edges late; a level flips after D straight
  // samples disagree with it; a pulsed hold of age h strobes at h=0 and h=RD+n*RP.
  logic [7:0]   m_s1, m_s2, m_lvl, m_syn;
  logic [D-1:0] m_win [8];
  int           m_mode [6];
  int           m_h [6];
  logic [5:0]   m_pulse;
  int           m_rst_cnt;
  logic         m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rst_cnt = 0;
      m_s1 = 8'hBF;
      m_s2 = 8'hBF;
      m_lvl = 8'h80;
      for (int i = 0; i < 8; i++) m_win[i] = {D{m_lvl[i]}};
      for (int k = 0; k < 6; k++) begin
        m_mode[k] = M_IDLE;
        m_h[k] = 0;
      end
      m_pulse = '0;
    end else if (m_rst_cnt < 2) begin
      m_rst_cnt++;
    end else begin
      m_syn = {m_s2[7:6], ~m_s2[5:0]};
      for (int k = 0; k < 6; k++) begin
        m_p = 1'b0;
        case (m_mode[k])
          M_HOLD: begin
            if (!m_lvl[6]) m_mode[k] = M_BLOCK;
            else if (!m_lvl[k]) m_mode[k] = M_IDLE;
            else begin
              m_h[k]++;
              m_p = (m_h[k] >= RD) && (((m_h[k] - RD) % RP) == 0);
            end
          end
          M_IDLE: begin
            if (m_lvl[k] && m_lvl[6]) begin
              m_mode[k] = M_HOLD;
              m_h[k] = 0;
              m_p = 1'b1;
            end else if (m_lvl[k]) begin
              m_mode[k] = M_BLOCK;
            end
          end
          default: if (!m_lvl[k]) m_mode[k] = M_IDLE;
        endcase
        m_pulse[k] = m_p;
      end
      for (int i = 0; i < 8; i++) begin
        m_win[i] = {m_win[i][D-2:0], m_syn[i]};
        if (m_win[i] == {D{~m_lvl[i]}}) m_lvl[i] = m_syn[i];
      end
      m_s2 = m_s1;
      m_s1 = {bus.dir_sw, bus.stop_sw, bus.key_n};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("adj_pulse", 32'(bus.adj_pulse), 32'(m_pulse));
      check("is_stop", 32'(bus.is_stop), 32'(m_lvl[6]));
      check("is_increase", 32'(bus.is_increase), 32'(m_lvl[7]));
    end
    for (int b = 0; b < 6; b++) if (bus.adj_pulse[b] === 1'b1) pcount[b]++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int ptotal();
    int s = 0;
    for (int b = 0; b < 6; b++) s += pcount[b];
    return s;
  endfunction

  // Hold the masked keys for 'hold' edges, observe 'win' edges; edge 1 is the first after the press.
  task automatic run_key(input logic [5:0] mask, input int hold, input int win,
                         output int cnt, output int cnt_ns, output int first,
                         output int gap1, output int gap2, output logic [5:0] fval);
    int e [3];
    int n_seen = 0;
    cnt = 0;
    cnt_ns = 0;
    fval = '0;
    for (int j = 0; j < 3; j++) e[j] = -100;
    bus.key_n = bus.key_n & ~mask;
    for (int n = 1; n <= win; n++) begin
      @(posedge clk);
      #1;
      if ((bus.adj_pulse & mask) != 6'b0) begin
        cnt++;
        if (!bus.is_stop) cnt_ns++;
        if (n_seen == 0) fval = bus.adj_pulse;
        if (n_seen < 3) e[n_seen] = n;
        n_seen++;
      end
      #1;
      if (n == hold) bus.key_n = bus.key_n | mask;
    end
    first = e[0];
    gap1 = e[1] - e[0];
    gap2 = e[2] - e[1];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  initial begin
    int cnt, cnt_ns, first, gap1, gap2, snap, dlat, lat;
    logic [5:0] fval;

    for (int b = 0; b < 6; b++) pcount[b] = 0;
    bus.key_n = 6'h00;
    bus.stop_sw = 1'b1;
    bus.dir_sw = 1'b0;
    rst_n = 1'b0;
    tick(4);
    chk_en = 1'b1;
    check("rst_adj_pulse", 32'(bus.adj_pulse), 32'h0);
    check("rst_is_stop", 32'(bus.is_stop), 32'h0);
    check("rst_is_increase", 32'(bus.is_increase), 32'h1);

    // Release reset with keys held and stop low: keys latch into the blocked state.
    bus.stop_sw = 1'b0;
    bus.dir_sw = 1'b1;
    snap = ptotal();
    rst_n = 1'b1;
    tick(20);
    check("post_rst_no_pulse", 32'(ptotal() - snap), 32'h0);
    bus.key_n = 6'h3F;
    tick(10);

    bus.stop_sw = 1'b1;
    tick(10);
    snap = pcount[1];
    bus.key_n[1] = 1'b0;
    tick(3);
    bus.key_n[1] = 1'b1;
    tick(12);
    check("glitch_no_pulse", 32'(pcount[1] - snap), 32'h0);
    run_key(6'b000010, 8, 20, cnt, cnt_ns, first, gap1, gap2, fval);
    check("press_latency", 32'(first), 32'd7);
    check("press_single", 32'(cnt), 32'd1);
    tick(5);

    run_key(6'b010000, 30, 45, cnt, cnt_ns, first, gap1, gap2, fval);
    check("repeat_first", 32'(first), 32'd7);
    check("repeat_delay", 32'(gap1), 32'd10);
    check("repeat_period", 32'(gap2), 32'd3);
    check("repeat_count", 32'(cnt), 32'd8);
    snap = pcount[4];
    tick(15);
    check("repeat_after_rel", 32'(pcount[4] - snap), 32'h0);

    // Key held before stop rises must not strobe until re-pressed.
    bus.stop_sw = 1'b0;
    tick(10);
    bus.key_n[0] = 1'b0;
    tick(12);
    bus.stop_sw = 1'b1;
    snap = pcount[0];
    tick(15);
    check("interlock_no_pulse", 32'(pcount[0] - snap), 32'h0);
    bus.key_n[0] = 1'b1;
    tick(12);
    fork
      run_key(6'b000001, 35, 45, cnt, cnt_ns, first, gap1, gap2, fval);
      begin
        repeat (18) @(posedge clk);
        #2 bus.stop_sw = 1'b0;
      end
    join
    check("stopdrop_first", 32'(first), 32'd7);
    check("stopdrop_count", 32'(cnt), 32'd4);
    check("stopdrop_no_pulse_when_stopped", 32'(cnt_ns), 32'h0);
    bus.stop_sw = 1'b1;
    tick(12);

    run_key(6'b100100, 8, 20, cnt, cnt_ns, first, gap1, gap2, fval);
    check("simul_value", 32'(fval), 32'h24);
    check("simul_count", 32'(cnt), 32'd1);
    check("simul_latency", 32'(first), 32'd7);
    tick(5);

    dlat = -1;
    fork
      run_key(6'b001000, 30, 40, cnt, cnt_ns, first, gap1, gap2, fval);
      begin
        repeat (14) @(posedge clk);
        #2 bus.dir_sw = 1'b0;
        for (int n = 1; n <= 12; n++) begin
          @(posedge clk);
          #1;
          if (!bus.is_increase && dlat < 0) dlat = n;
        end
      end
    join
    check("dir_latency", 32'(dlat), 32'd6);
    check("dir_cadence_count", 32'(cnt), 32'd8);
    check("dir_cadence_period", 32'(gap2), 32'd3);
    tick(10);

    // Reset asserted while a key sits in its repeat delay.
    bus.key_n[2] = 1'b0;
    tick(10);
    rst_n = 1'b0;
    #1;
    check("async_rst_adj_pulse", 32'(bus.adj_pulse), 32'h0);
    check("async_rst_is_stop", 32'(bus.is_stop), 32'h0);
    check("async_rst_is_increase", 32'(bus.is_increase), 32'h1);
    #1;
    tick(3);
    rst_n = 1'b1;
    lat = -1;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1;
      if (bus.adj_pulse[2] && lat < 0) lat = n;
      #1;
    end
    check("rst_release_latency", 32'(lat), 32'd9);
    bus.key_n[2] = 1'b1;
    tick(15);

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) == 0) bus.stop_sw = ~bus.stop_sw;
      if ($urandom_range(0, 9) == 0) bus.dir_sw = ~bus.dir_sw;
      bus.key_n = bus.key_n ^ (6'($urandom) & 6'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      tick($urandom_range(1, 20));
    end

    bus.key_n = 6'h3F;
    tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
